// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures, RESP holds the result.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_A,
    input  logic [2*WIDTH-1:0] req_B,
    input  logic [7:0]         req_sel,
    input  logic [1:0]         req_B_sel,
    input  logic [9:0]         req_shamt,
    output logic [WIDTH-1:0]   alu_data_A,
    output logic [WIDTH-1:0]   alu_data_B,
    output logic [3:0]         alu_sel,
    output logic               alu_B_sel,
    output logic [4:0]         alu_shamt,
    input  logic [WIDTH-1:0]   alu_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic             ptr;
    logic             gnt_id;
    logic [1:0]       grant;
    logic             accept;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_sel;
    logic             op_b_sel;
    logic [4:0]       op_shamt;
    logic             op_id;

    // Pointer only matters on contention; a lone requester always wins.
    always_comb begin
        gnt_id = 1'b0;
        if (&req_valid) begin
            gnt_id = ptr;
        end else if (req_valid[1]) begin
            gnt_id = 1'b1;
        end
        grant = 2'b00;
        if (|req_valid) begin
            grant = gnt_id ? 2'b10 : 2'b01;
        end
        req_ready = (state == IDLE && !reset) ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
    end

    assign alu_data_A = op_a;
    assign alu_data_B = op_b;
    assign alu_sel    = op_sel;
    assign alu_B_sel  = op_b_sel;
    assign alu_shamt  = op_shamt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            op_b_sel  <= 1'b0;
            op_shamt  <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a     <= gnt_id ? req_A[2*WIDTH-1:WIDTH]
                                           : req_A[WIDTH-1:0];
                        op_b     <= gnt_id ? req_B[2*WIDTH-1:WIDTH]
                                           : req_B[WIDTH-1:0];
                        op_sel   <= gnt_id ? req_sel[7:4] : req_sel[3:0];
                        op_b_sel <= gnt_id ? req_B_sel[1] : req_B_sel[0];
                        op_shamt <= gnt_id ? req_shamt[9:5] : req_shamt[4:0];
                        op_id    <= gnt_id;
                        ptr      <= ~gnt_id;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a queue-based
// reference model; the shared ALU is modelled behaviourally here.
module tb_alu_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_A;
    logic [2*W-1:0] req_B;
    logic [7:0]     req_sel;
    logic [1:0]     req_B_sel;
    logic [9:0]     req_shamt;
    logic [W-1:0]   alu_data_A;
    logic [W-1:0]   alu_data_B;
    logic [3:0]     alu_sel;
    logic           alu_B_sel;
    logic [4:0]     alu_shamt;
    logic [W-1:0]   alu_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_data;

    int tests = 0;
    int fails = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_sel    (req_sel),
        .req_B_sel  (req_B_sel),
        .req_shamt  (req_shamt),
        .alu_data_A (alu_data_A),
        .alu_data_B (alu_data_B),
        .alu_sel    (alu_sel),
        .alu_B_sel  (alu_B_sel),
        .alu_shamt  (alu_shamt),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b,
                                           logic [3:0] s, logic [4:0] sh);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return W'($signed(a) >>> sh);
            4'd8:    return W'($signed(a) < $signed(b));
            4'd9:    return W'(a < b);
            4'd10:   return b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_data_A, alu_data_B, alu_sel, alu_shamt);

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b,
                           logic [3:0] s, logic bs, logic [4:0] sh);
        req_A[i*W +: W]   = a;
        req_B[i*W +: W]   = b;
        req_sel[i*4 +: 4] = s;
        req_B_sel[i]      = bs;
        req_shamt[i*5 +: 5] = sh;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        settle();
    endtask

    typedef struct {
        logic         id;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t         q[$];
    int           age;
    logic         mptr;
    logic [1:0]   exp_rdy;
    logic         exp_vld;
    logic         gid;

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_A     = '0;
        req_B     = '0;
        req_sel   = '0;
        req_B_sel = '0;
        req_shamt = '0;
        rsp_ready = 1'b1;
        tick();
        req_valid = 2'b11;
        settle();
        chk("rst_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        chk("rst_aluA", 64'(alu_data_A), 64'd0);
        reset = 1'b0;
        req_valid = 2'b00;
        tick();

        // Single add with latency check
        set_req(0, 32'h33333333, 32'd1311, 4'd0, 1'b1, 5'd0);
        req_valid = 2'b01;
        settle();
        chk("single_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        set_req(0, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0);
        settle();
        chk("exec_valid", 64'(rsp_valid), 64'd0);
        chk("exec_ready", 64'(req_ready), 64'd0);
        chk("exec_aluA", 64'(alu_data_A), 64'h33333333);
        chk("exec_bsel", 64'(alu_B_sel), 64'd1);
        tick();
        chk("single_valid", 64'(rsp_valid), 64'd1);
        chk("single_id", 64'(rsp_id), 64'd0);
        chk("single_data", 64'(rsp_data), 64'h33333852);
        tick();
        chk("single_done", 64'(rsp_valid), 64'd0);

        // Contention from reset: grants alternate 0,1,0,1
        do_reset();
        set_req(0, 32'd10, 32'd3, 4'd1, 1'b0, 5'd0);
        set_req(1, 32'd10, 32'd3, 4'd4, 1'b0, 5'd0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_grant", 64'(req_ready), (k % 2) ? 64'(2'b10) : 64'(2'b01));
            tick();
            tick();
            chk("rr_id", 64'(rsp_id), 64'(k % 2));
            chk("rr_data", 64'(rsp_data), (k % 2) ? 64'd9 : 64'd7);
            tick();
        end
        req_valid = 2'b00;

        // Shift from requester 1 held under backpressure
        set_req(1, 32'h99999999, 32'h0, 4'd7, 1'b0, 5'd12);
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        settle();
        chk("sra_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b11;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_id", 64'(rsp_id), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'hFFF99999);
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        tick();
        chk("bp_release", 64'(rsp_valid), 64'd0);
        chk("bp_ptr", 64'(req_ready), 64'(2'b01));
        req_valid = 2'b00;
        tick();

        // Reset during EXEC aborts the operation and clears the pointer
        set_req(0, 32'd1, 32'd2, 4'd0, 1'b0, 5'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        reset = 1'b1;
        settle();
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0;
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("abort_valid", 64'(rsp_valid), 64'd0);
            tick();
        end
        req_valid = 2'b11;
        settle();
        chk("abort_ptr", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        tick();

        // Withdraw before accept: no transfer, pointer still 1
        req_valid = 2'b01;
        settle();
        chk("wd_offer", 64'(req_ready), 64'(2'b01));
        req_valid = 2'b00;
        settle();
        chk("wd_drop", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wd_valid", 64'(rsp_valid), 64'd0);
        end
        req_valid = 2'b11;
        settle();
        chk("wd_ptr", 64'(req_ready), 64'(2'b10));
        req_valid = 2'b00;

        // Randomized traffic against the queue model
        do_reset();
        mptr = 1'b0;
        age = 0;
        for (int n = 0; n < 400; n++) begin
            req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                set_req(i, $urandom, $urandom, 4'($urandom_range(0, 10)),
                        1'($urandom), 5'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle();
            exp_rdy = 2'b00;
            gid = 1'b0;
            if (q.size() == 0 && req_valid != 2'b00) begin
                gid = (req_valid == 2'b11) ? mptr : req_valid[1];
                exp_rdy = gid ? 2'b10 : 2'b01;
            end
            exp_vld = (q.size() > 0) && (age >= 1);
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rnd_valid", 64'(rsp_valid), 64'(exp_vld));
            if (exp_vld) begin
                chk("rnd_id", 64'(rsp_id), 64'(q[0].id));
                chk("rnd_data", 64'(rsp_data), 64'(q[0].data));
            end
            if (exp_rdy != 2'b00) begin
                q.push_back('{id: gid,
                              data: alu_f(req_A[gid*W +: W], req_B[gid*W +: W],
                                          req_sel[gid*4 +: 4],
                                          req_shamt[gid*5 +: 5])});
                age = 0;
                mptr = ~gid;
            end else if (q.size() > 0) begin
                if (exp_vld && rsp_ready) begin
                    void'(q.pop_front());
                end else begin
                    age++;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
